// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer writer: FSM encodings, pixel word
// field positions and default framebuffer geometry.
package fb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_READ       = 4'd1,
    ST_LATCH      = 4'd2,
    ST_CALC       = 4'd3,
    ST_REQ        = 4'd4,
    ST_WAIT_CMPLT = 4'd5
  } fbw_state_e;

  localparam int X_MSB      = 95;
  localparam int X_LSB      = 64;
  localparam int Y_MSB      = 63;
  localparam int Y_LSB      = 32;
  localparam int COLOUR_MSB = 31;
  localparam int COLOUR_LSB = 0;

  localparam logic [31:0] DEF_FB_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_FB_WIDTH     = 32'd640;
  localparam logic [31:0] DEF_FB_HEIGHT    = 32'd480;

  // Byte offset of a 32-bit pixel; product and sum deliberately wrap at 32 bits.
  function automatic logic [31:0] pixel_offset(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] width);
    logic [31:0] lin;
    lin = (y * width) + x;
    return {lin[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational pixel address generator and on-screen check.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE_ADDR = DEF_FB_BASE_ADDR,
  parameter logic [31:0] FB_WIDTH     = DEF_FB_WIDTH,
  parameter logic [31:0] FB_HEIGHT    = DEF_FB_HEIGHT
) (
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_addr,
  output logic        o_in_range
);

  assign o_in_range = (i_x < FB_WIDTH) && (i_y < FB_HEIGHT);
  assign o_addr     = FB_BASE_ADDR + pixel_offset(i_x, i_y, FB_WIDTH);

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: pops one pixel from a non-FWFT FIFO and issues one
// single-beat PLB master write for it, dropping off-screen pixels.
module fb_writer
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE_ADDR = DEF_FB_BASE_ADDR,
  parameter logic [31:0] FB_WIDTH     = DEF_FB_WIDTH,
  parameter logic [31:0] FB_HEIGHT    = DEF_FB_HEIGHT
) (
  input  logic        PLB_clk,
  input  logic        reset_n,
  input  logic [95:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        IP2Bus_MstWr_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  output logic [31:0] IP2Bus_MstWr_d,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  output logic [3:0]  fbw_state
);

  fbw_state_e  r_state;
  fbw_state_e  w_next_state;
  logic        r_rd_en;
  logic        w_rd_en_next;
  logic        r_req;
  logic        w_req_next;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_colour;
  logic        r_in_range;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] w_gen_x;
  logic [31:0] w_gen_y;
  logic [31:0] w_addr;
  logic        w_in_range;

  // The generator sees the live FIFO word while latching, the held pixel otherwise.
  assign w_gen_x = (r_state == ST_LATCH) ? fifo_data[X_MSB:X_LSB] : r_x;
  assign w_gen_y = (r_state == ST_LATCH) ? fifo_data[Y_MSB:Y_LSB] : r_y;

  fb_addr_gen #(
    .FB_BASE_ADDR (FB_BASE_ADDR),
    .FB_WIDTH     (FB_WIDTH),
    .FB_HEIGHT    (FB_HEIGHT)
  ) u_addr_gen (
    .i_x        (w_gen_x),
    .i_y        (w_gen_y),
    .o_addr     (w_addr),
    .o_in_range (w_in_range)
  );

  always_comb begin
    w_next_state = r_state;
    w_rd_en_next = 1'b0;
    w_req_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_next_state = ST_READ;
          w_rd_en_next = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ:  w_next_state = ST_LATCH;
      ST_LATCH: w_next_state = ST_CALC;
      ST_CALC: begin
        if (r_in_range) begin
          w_next_state = ST_REQ;
          w_req_next   = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (Bus2IP_Mst_CmdAck) begin
          w_next_state = Bus2IP_Mst_Cmplt ? ST_IDLE : ST_WAIT_CMPLT;
        end else begin
          w_next_state = ST_REQ;
          w_req_next   = 1'b1;
        end
      end
      ST_WAIT_CMPLT: begin
        if (Bus2IP_Mst_Cmplt) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_CMPLT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rd_en <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rd_en <= w_rd_en_next;
      r_req   <= w_req_next;
    end
  end

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= 32'd0;
      r_y        <= 32'd0;
      r_colour   <= 32'd0;
      r_in_range <= 1'b0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
    end else begin
      if (r_state == ST_LATCH) begin
        r_x        <= fifo_data[X_MSB:X_LSB];
        r_y        <= fifo_data[Y_MSB:Y_LSB];
        r_colour   <= fifo_data[COLOUR_MSB:COLOUR_LSB];
        r_in_range <= w_in_range;
      end
      // Bus address/data only change when a new on-screen pixel is committed.
      if ((r_state == ST_CALC) && r_in_range) begin
        r_addr <= w_addr;
        r_data <= r_colour;
      end
    end
  end

  assign fifo_rd_en       = r_rd_en;
  assign IP2Bus_MstWr_Req = r_req;
  assign IP2Bus_Mst_Addr  = r_addr;
  assign IP2Bus_MstWr_d   = r_data;
  assign fbw_state        = r_state;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer with a FIFO model, a PLB slave responder and a
// scoreboard of expected write beats.
module tb_fb_writer;

  logic        PLB_clk;
  logic        reset_n;
  logic [95:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [31:0] IP2Bus_MstWr_d;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic [3:0]  fbw_state;

  fb_writer dut (
    .PLB_clk           (PLB_clk),
    .reset_n           (reset_n),
    .fifo_data         (fifo_data),
    .fifo_empty        (fifo_empty),
    .fifo_rd_en        (fifo_rd_en),
    .IP2Bus_MstWr_Req  (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr   (IP2Bus_Mst_Addr),
    .IP2Bus_MstWr_d    (IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck (Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt  (Bus2IP_Mst_Cmplt),
    .fbw_state         (fbw_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int req_cnt = 0;
  int wait_cnt = 0;

  logic [95:0] pix_q[$];
  logic [63:0] sb_q[$];

  int ack_dly = 1;
  int cmplt_gap = 0;
  bit stale = 1'b0;
  bit bus_busy = 1'b0;

  initial begin
    PLB_clk = 1'b0;
    forever #5 PLB_clk = ~PLB_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    logic [31:0] a;
    pix_q.push_back({x, y, c});
    if ((x < 32'd640) && (y < 32'd480)) begin
      a = 32'h8000_0000 + (((y * 32'd640) + x) * 32'd4);
      sb_q.push_back({a, c});
    end
  endtask

  task automatic drain(input string tag);
    int stable = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PLB_clk);
      if (pix_q.size() == 0 && fbw_state == 4'd0 && !bus_busy && !fifo_rd_en) stable++;
      else stable = 0;
      if (stable >= 4) break;
    end
    check(tag, (stable >= 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // FIFO model: data appears on the edge after the sampled read strobe.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = 96'd0;
    forever begin
      @(negedge PLB_clk);
      fifo_empty = (pix_q.size() == 0);
      if (fifo_rd_en === 1'b1) begin
        @(posedge PLB_clk);
        if (pix_q.size() > 0) fifo_data = pix_q.pop_front();
      end
    end
  end

  // PLB slave: ack after ack_dly cycles, complete with it or cmplt_gap cycles later.
  initial begin
    Bus2IP_Mst_CmdAck = 1'b0;
    Bus2IP_Mst_Cmplt  = 1'b0;
    forever begin
      @(negedge PLB_clk);
      if (IP2Bus_MstWr_Req === 1'b1 && !bus_busy) begin
        bus_busy = 1'b1;
        repeat (ack_dly) @(negedge PLB_clk);
        Bus2IP_Mst_CmdAck = 1'b1;
        if (cmplt_gap == 0) Bus2IP_Mst_Cmplt = 1'b1;
        @(negedge PLB_clk);
        if (stale) @(negedge PLB_clk);
        Bus2IP_Mst_CmdAck = 1'b0;
        Bus2IP_Mst_Cmplt  = 1'b0;
        if (cmplt_gap > 0) begin
          repeat (cmplt_gap - 1 - (stale ? 1 : 0)) @(negedge PLB_clk);
          Bus2IP_Mst_Cmplt = 1'b1;
          @(negedge PLB_clk);
          Bus2IP_Mst_Cmplt = 1'b0;
        end
        bus_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on each request rise plus protocol checks.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_rd = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_data = 32'd0;
    logic [63:0] e;
    forever begin
      @(negedge PLB_clk);
      if (reset_n === 1'b1) begin
        if (fifo_rd_en) begin
          rd_cnt++;
          check("rd_en_in_read", {28'd0, fbw_state}, 32'd1);
          check("rd_en_one_cycle", {31'd0, prev_rd}, 32'd0);
          check("rd_en_while_busy", {31'd0, bus_busy}, 32'd0);
        end
        if (fbw_state == 4'd5) begin
          wait_cnt++;
          check("req_low_in_wait", {31'd0, IP2Bus_MstWr_Req}, 32'd0);
        end
        if (IP2Bus_MstWr_Req && !prev_req) begin
          req_cnt++;
          if (sb_q.size() == 0) begin
            check("sb_unexpected_req", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("wr_addr", IP2Bus_Mst_Addr, e[63:32]);
            check("wr_data", IP2Bus_MstWr_d, e[31:0]);
          end
        end else if (IP2Bus_MstWr_Req && prev_req) begin
          check("addr_stable", IP2Bus_Mst_Addr, prev_addr);
          check("data_stable", IP2Bus_MstWr_d, prev_data);
        end
        prev_req  = IP2Bus_MstWr_Req;
        prev_rd   = fifo_rd_en;
        prev_addr = IP2Bus_Mst_Addr;
        prev_data = IP2Bus_MstWr_d;
      end else begin
        prev_req = 1'b0;
        prev_rd  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0;
    int req0;
    int w0;
    bit found;

    // Reset with a pixel pending: no outputs until release.
    reset_n = 1'b0;
    ack_dly = 1; cmplt_gap = 0; stale = 1'b1;
    push_pix(32'd10, 32'd2, 32'h00FF_00FF);
    repeat (3) @(negedge PLB_clk);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_req", {31'd0, IP2Bus_MstWr_Req}, 32'd0);
    check("rst_state", {28'd0, fbw_state}, 32'd0);
    check("rst_addr", IP2Bus_Mst_Addr, 32'd0);
    check("rst_data", IP2Bus_MstWr_d, 32'd0);
    reset_n = 1'b1;
    @(negedge PLB_clk);
    check("rst_first_rdpulse", {31'd0, fifo_rd_en}, 32'd1);

    // Single pixel with a stale ack after the request falls.
    drain("single_drain");
    check("single_req_cnt", req_cnt, 32'd1);
    check("single_rd_cnt", rd_cnt, 32'd1);
    check("single_addr_hold", IP2Bus_Mst_Addr, 32'h8000_1428);
    stale = 1'b0;

    // Clipped pixels: consumed, never written.
    rd0 = rd_cnt; req0 = req_cnt;
    push_pix(32'd640, 32'd0, 32'h1111_1111);
    push_pix(32'd0, 32'd480, 32'h2222_2222);
    drain("clip_drain");
    check("clip_rd_cnt", rd_cnt - rd0, 32'd2);
    check("clip_req_cnt", req_cnt - req0, 32'd0);
    check("clip_state", {28'd0, fbw_state}, 32'd0);

    // Split ack: completion three cycles after the command ack.
    ack_dly = 1; cmplt_gap = 3;
    req0 = req_cnt; w0 = wait_cnt;
    push_pix(32'd100, 32'd50, 32'hCAFE_0001);
    drain("split_drain");
    check("split_req_cnt", req_cnt - req0, 32'd1);
    check("split_wait_cycles", wait_cnt - w0, 32'd3);

    // Back-to-back corners with same-edge ack and completion.
    ack_dly = 0; cmplt_gap = 0;
    req0 = req_cnt;
    push_pix(32'd0, 32'd0, 32'hA5A5_0000);
    push_pix(32'd639, 32'd479, 32'h5A5A_FFFF);
    drain("b2b_drain");
    check("b2b_req_cnt", req_cnt - req0, 32'd2);
    check("b2b_last_addr", IP2Bus_Mst_Addr, 32'h8012_BFFC);

    // Reset while the request is up: the pixel is lost.
    ack_dly = 1; cmplt_gap = 0;
    push_pix(32'd1, 32'd1, 32'hDEAD_BEEF);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PLB_clk);
      if (fbw_state == 4'd4) begin found = 1'b1; break; end
    end
    check("midrst_reached_req", {31'd0, found}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, IP2Bus_MstWr_Req}, 32'd0);
    check("midrst_state", {28'd0, fbw_state}, 32'd0);
    repeat (3) @(negedge PLB_clk);
    reset_n = 1'b1;
    req0 = req_cnt;
    push_pix(32'd3, 32'd4, 32'h0BAD_F00D);
    drain("resume_drain");
    check("resume_req_cnt", req_cnt - req0, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Framebuffer writer: drains rasterised pixels from the core's 96-bit pixel FIFO and issues one single-beat PLB master write per pixel to the framebuffer in memory.
- Sits between the graphics core's pixel FIFO read port and the PLB master IPIF.
- Handles one pixel at a time, fully handshaken. Off-screen pixels are consumed and dropped.

Parameters:
- FB_BASE_ADDR, 32'h8000_0000, byte address of pixel (0,0).
- FB_WIDTH, 640, pixels per line.
- FB_HEIGHT, 480, number of lines.

Ports:
- PLB_clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_data  in  96  pixel word: [95:64]=x (unsigned), [63:32]=y (unsigned), [31:0]=colour.
- fifo_empty  in  1  pixel FIFO empty flag.
- fifo_rd_en  out  1  one-cycle read strobe; FIFO data is valid the cycle after it (standard, non-FWFT).
- IP2Bus_MstWr_Req  out  1  write request.
- IP2Bus_Mst_Addr  out  32  write byte address.
- IP2Bus_MstWr_d  out  32  write data (colour).
- Bus2IP_Mst_CmdAck  in  1  command accepted.
- Bus2IP_Mst_Cmplt  in  1  transfer complete; may coincide with CmdAck.
- fbw_state  out  4  current FSM state, for debug.

Behaviour:
- Reset (async, reset_n=0):
  - fifo_rd_en=0, IP2Bus_MstWr_Req=0.
  - Addr=0, data=0, state=IDLE.
- FSM states and encodings: IDLE=0, READ=1, LATCH=2, CALC=3, REQ=4, WAIT_CMPLT=5. Unused codes go to IDLE.
- IDLE:
  - If fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to READ.
  - Otherwise stay. Bus inputs are ignored.
- READ: wait one cycle for FIFO data; go to LATCH.
- LATCH:
  - Register x, y and colour from fifo_data.
  - Register in_range = (x < FB_WIDTH) && (y < FB_HEIGHT).
  - Go to CALC.
- CALC:
  - If in_range: register addr = FB_BASE_ADDR + ((y*FB_WIDTH + x) << 2), using a 32-bit wrap-around sum. Register data = colour. Go to REQ.
  - Else: drop the pixel, no bus activity, go to IDLE.
- REQ:
  - IP2Bus_MstWr_Req=1; Addr and data are held stable.
  - On the first edge with CmdAck=1, Req drops the next cycle.
  - If Cmplt=1 on the same edge, go to IDLE; otherwise go to WAIT_CMPLT.
- WAIT_CMPLT: Req=0; go to IDLE on Cmplt=1.
- Bus outputs:
  - Req is registered.
  - Addr and data hold their last values outside REQ.
- Stale inputs: CmdAck/Cmplt seen in IDLE, READ, LATCH or CALC are ignored. The PLB may leave ack high one cycle after Req falls.
- Throughput:
  - One pixel in flight.
  - Minimum 6 cycles per pixel with same-cycle CmdAck+Cmplt returned one cycle after Req rises.
  - The next fifo_rd_en never precedes completion of the prior write.
- Reset mid-transfer: immediately returns to IDLE with Req=0. The in-flight pixel is lost.
- Arithmetic: y*FB_WIDTH uses a 32-bit product, truncated. The range check uses the full 32-bit x and y.

Decomposition:
- Shared package fb_pkg holds:
  - state encodings;
  - FIFO field bit positions (X_MSB/LSB, Y_MSB/LSB, COLOUR_MSB/LSB);
  - the default framebuffer geometry constants.
- Natural sub-module: fb_addr_gen. It is combinational; given x, y, FB_WIDTH, FB_HEIGHT and FB_BASE_ADDR it returns addr and in_range.
- The FSM and handshake stay in fb_writer.

Test Plan:
- Reset: hold reset_n=0 with fifo_empty=0 → fifo_rd_en=0, Req=0, fbw_state=0. Release → fifo_rd_en pulses one cycle on the first edge.
- Single pixel: x=10, y=2, colour=32'h00FF00FF; bus acks CmdAck=Cmplt=1 one cycle after Req → Req with Addr=32'h8000_1428 and data=32'h00FF00FF. Exactly one Req episode, then IDLE. The stale ack cycle causes no second request.
- Clipping: x=640, y=0, then x=0, y=480 → both consumed (one fifo_rd_en each), no Req asserted, FSM returns to IDLE.
- Split ack: CmdAck 1 cycle after Req, Cmplt 3 cycles later → Req low the cycle after CmdAck, fbw_state=5 until Cmplt, no fifo_rd_en meanwhile.
- Back-to-back: pixels (0,0) and (639,479) queued → addresses 32'h8000_0000 then 32'h8012_BFFC in order, with the second rd_en only after the first Cmplt.
- Reset mid-operation: assert reset_n=0 while in REQ → Req falls asynchronously, state=IDLE. Resumes normally after release.
